// File: rtl/stack_pkg.sv
// Shared types and default sizes for the hardware operand stack controller.
package stack_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic [2:0] {IDLE, PUSH, RD, RD_WAIT, DONE} state_t;
    typedef enum logic [1:0] {CMD_PUSH, CMD_POP, CMD_TOS} cmd_t;
endpackage

// File: rtl/stack_ram.sv
// Single-port, write-first, synchronous-read stack RAM (DEPTH x DATA_W).
module stack_ram import stack_pkg::*; #(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/stack_sequencer.sv
// Multicycle push/pop/tos controller for an external synchronous-read stack RAM.
// Optional full/empty protection with sticky ovf/udf flags: STACK_BOUNDS_CHECK_EN.
module stack_sequencer import stack_pkg::*; #(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic [AW:0]       sp,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              udf,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    state_t            state, nstate;
    cmd_t              cmd_q;
    logic [DATA_W-1:0] din_q;
    logic [AW:0]       sp_q, sp_inc, sp_dec;
    logic              rej_push, rej_rd;

    assign sp    = sp_q;
    assign empty = (sp_q == '0);

`ifdef STACK_BOUNDS_CHECK_EN
    logic ovf_q, udf_q;

    assign full     = (sp_q == (AW+1)'(DEPTH));
    assign ovf      = ovf_q;
    assign udf      = udf_q;
    assign rej_push = full;
    assign rej_rd   = empty;
    assign sp_inc   = sp_q + (AW+1)'(1);
    assign sp_dec   = sp_q - (AW+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (state == IDLE) begin
            if (push && full)
                ovf_q <= 1'b1;
            else if (!push && (pop || tos) && empty)
                udf_q <= 1'b1;
        end
    end
`else
    // Unprotected build: pointer is a pure modulo-DEPTH counter.
    assign full     = 1'b0;
    assign ovf      = 1'b0;
    assign udf      = 1'b0;
    assign rej_push = 1'b0;
    assign rej_rd   = 1'b0;
    assign sp_inc   = {1'b0, sp_q[AW-1:0] + AW'(1)};
    assign sp_dec   = {1'b0, sp_q[AW-1:0] - AW'(1)};
`endif

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign ram_we    = (state == PUSH) && !rst;
    assign ram_wdata = din_q;
    assign ram_addr  = (state == PUSH) ? sp_q[AW-1:0] : sp_q[AW-1:0] - AW'(1);

    always_comb begin
        nstate = state;
        case (state)
            IDLE: begin
                if (push)
                    nstate = rej_push ? DONE : PUSH;
                else if (pop || tos)
                    nstate = rej_rd ? DONE : RD;
            end
            PUSH:    nstate = DONE;
            RD:      nstate = RD_WAIT;
            RD_WAIT: nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmd_q <= CMD_PUSH;
            din_q <= '0;
            sp_q  <= '0;
            dout  <= '0;
        end else begin
            state <= nstate;
            case (state)
                IDLE: begin
                    if (push) begin
                        cmd_q <= CMD_PUSH;
                        din_q <= din;
                    end else if (pop) begin
                        cmd_q <= CMD_POP;
                    end else if (tos) begin
                        cmd_q <= CMD_TOS;
                    end
                end
                PUSH: begin
                    sp_q <= sp_inc;
                    dout <= din_q;
                end
                RD_WAIT: begin
                    dout <= ram_rdata;
                    if (cmd_q == CMD_POP)
                        sp_q <= sp_dec;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized bench for stack_sequencer + stack_ram against an array-based stack model.
module tb_stack_sequencer;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;
`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, push = 1'b0, pop = 1'b0, tos = 1'b0;
    logic [DW-1:0] din = '0;
    logic busy, done, empty, full, ovf, udf, ram_we;
    logic [DW-1:0] dout, ram_wdata, ram_rdata;
    logic [AW:0] sp;
    logic [AW-1:0] ram_addr;

    always #5 clk = ~clk;

    stack_sequencer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
        .busy(busy), .done(done), .dout(dout), .sp(sp), .empty(empty), .full(full),
        .ovf(ovf), .udf(udf), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    stack_ram #(.DATA_W(DW), .DEPTH(DEPTH)) ram (
        .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference stack
    logic [DW-1:0] mem_m [DEPTH];
    bit            known_m [DEPTH];
    int            sp_m = 0;
    logic [DW-1:0] dout_m = '0;
    bit            dout_known = 1'b1;
    bit            ovf_m = 1'b0, udf_m = 1'b0;

    task automatic check_status();
        chk("empty", empty, (sp_m == 0));
        chk("full", full, (CHK && sp_m == DEPTH));
        chk("ovf", ovf, ovf_m);
        chk("udf", udf, udf_m);
    endtask

    task automatic do_cmd(input logic p, input logic q, input logic t, input logic [DW-1:0] d);
        int lat_exp, we_exp, lat, we_cnt, a, sp_done;
        bit rd_exp;
        logic [AW-1:0] wa_exp, ra_exp, wa, ra;
        logic [DW-1:0] wd_exp, wd, dout_done;
        if (!(p || q || t)) begin
            @(posedge clk); #1;
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
            return;
        end
        rd_exp = 1'b0; we_exp = 0; lat_exp = 0;
        wa_exp = '0; ra_exp = '0; wd_exp = '0;
        if (p) begin
            if (CHK && sp_m == DEPTH) begin
                ovf_m = 1'b1; lat_exp = 1;
            end else begin
                a = sp_m % DEPTH;
                wa_exp = a[AW-1:0]; wd_exp = d;
                mem_m[a] = d; known_m[a] = 1'b1;
                dout_m = d; dout_known = 1'b1;
                sp_m = CHK ? sp_m + 1 : (sp_m + 1) % DEPTH;
                we_exp = 1; lat_exp = 2;
            end
        end else begin
            if (CHK && sp_m == 0) begin
                udf_m = 1'b1; lat_exp = 1;
            end else begin
                a = (sp_m + DEPTH - 1) % DEPTH;
                ra_exp = a[AW-1:0]; rd_exp = 1'b1;
                dout_m = mem_m[a]; dout_known = known_m[a];
                if (q) sp_m = (sp_m + DEPTH - 1) % DEPTH;
                lat_exp = 3;
            end
        end
        push = p; pop = q; tos = t; din = d;
        lat = 0; we_cnt = 0; wa = '0; wd = '0; ra = '0; sp_done = 0; dout_done = '0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (ram_we) begin we_cnt++; wa = ram_addr; wd = ram_wdata; end
            if (k == 1) ra = ram_addr;
            if (done) begin lat = k; sp_done = int'(sp); dout_done = dout; end
            // commands while busy must be ignored
            push = 1'($urandom); pop = 1'($urandom); tos = 1'($urandom); din = DW'($urandom);
        end
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0;
        chk("latency", lat, lat_exp);
        chk("we_cnt", we_cnt, we_exp);
        if (we_exp != 0) begin
            chk("wr_addr", wa, wa_exp);
            chk("wr_data", wd, wd_exp);
        end
        if (rd_exp) chk("rd_addr", ra, ra_exp);
        chk("sp", sp_done, sp_m);
        if (dout_known) chk("dout", dout_done, dout_m);
        chk("busy_after", busy, 1'b0);
        check_status();
    endtask

    initial begin
        logic [2:0] c;
        for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_sp", sp, 0);
        chk("rst_dout", dout, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", ram_we, 0);
        check_status();

        do_cmd(1, 0, 0, 8'h11);
        do_cmd(1, 0, 0, 8'h22);
        do_cmd(1, 0, 0, 8'h33);
        do_cmd(0, 0, 1, 8'h00);
        repeat (3) do_cmd(0, 1, 0, 8'h00);
        do_cmd(1, 1, 0, 8'h5A);
        do_cmd(0, 1, 0, 8'h00);

        for (int i = 0; i < DEPTH; i++) do_cmd(1, 0, 0, DW'($urandom));
        do_cmd(1, 0, 0, 8'hFF);
        for (int i = 0; i < 2 * DEPTH && sp_m != 0; i++) do_cmd(0, 1, 0, 8'h00);
        do_cmd(0, 1, 0, 8'h00);

        for (int i = 0; i < 60; i++) begin
            c = 3'($urandom_range(0, 7));
            do_cmd(c[0], c[1], c[2], DW'($urandom));
        end

        // reset during the PUSH state of a push
        push = 1'b1; din = 8'h77;
        @(posedge clk); #1;
        push = 1'b0;
        chk("we_pre_rst", ram_we, 1'b1);
        rst = 1'b1; #1;
        chk("we_in_rst", ram_we, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        sp_m = 0; dout_m = '0; dout_known = 1'b1; ovf_m = 1'b0; udf_m = 1'b0;
        chk("rst2_sp", sp, 0);
        chk("rst2_dout", dout, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_done", done, 0);
        check_status();
        do_cmd(0, 0, 1, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
